mux_nx1_reg: RTL and testbench
==============================

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width per channel in bits.
REQ-003 The block SHALL have derived localparam SW = max(1, ceil(log2(N))), meaning the select and channel-index width.
REQ-004 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port x  input  N*W  channel data, flat; channel i occupies x[i*W +: W].
REQ-007 Port x_valid  input  N  per-channel data-valid.
REQ-008 Port x_ready  output  N  per-channel accept; combinational; at most one bit high per cycle.
REQ-009 Port s  input  SW  channel select, used in fixed mode only.
REQ-010 Port mode  input  1  0 = fixed select by s; 1 = round-robin across valid channels.
REQ-011 Port f  output  W  registered output data.
REQ-012 Port f_valid  output  1  output register holds a word.
REQ-013 Port f_ready  input  1  downstream accepts f this cycle.
REQ-014 Port f_sel  output  SW  index of the channel that supplied the word in f.

Function
REQ-015 A one-entry output register SHALL hold f, f_sel and f_valid.
REQ-016 Load enable SHALL be ld = ~f_valid | f_ready.
REQ-017 In fixed mode, the candidate channel SHALL be c = s, and a grant SHALL occur only if s < N and x_valid[s] = 1.
REQ-018 In round-robin mode, the candidate channel SHALL be the first i with x_valid[i] = 1, searching ptr, ptr+1, ... mod N.
REQ-019 In round-robin mode, a grant SHALL occur if any x_valid bit is 1.
REQ-020 x_ready[c] SHALL be 1 only when ld = 1 and channel c is granted; all other x_ready bits SHALL be 0.
REQ-021 On accept (x_valid[c] & x_ready[c]), the next edge SHALL load f <= x[c], f_sel <= c and f_valid <= 1.
REQ-022 Latency from accept to f_valid SHALL be exactly 1 cycle.
REQ-023 Throughput SHALL be 1 word per cycle while f_ready = 1 and a grant exists.
REQ-024 When ld = 1 and there is no grant, the next edge SHALL set f_valid <= 0.
REQ-025 When ld = 1 and there is no grant, f and f_sel SHALL hold their values.
REQ-026 When f_valid = 1 and f_ready = 0, f, f_sel and f_valid SHALL hold, and all x_ready bits SHALL be 0.
REQ-027 A simultaneous output handshake and new accept in the same cycle SHALL replace the register contents with no bubble.
REQ-028 The round-robin pointer ptr (SW bits) SHALL update to (c+1) mod N on every accept, in either mode.
REQ-029 ptr SHALL wrap from N-1 to 0, also when N is not a power of two.
REQ-030 A change of mode or s SHALL take effect combinationally in the same cycle.
REQ-031 A change of mode or s SHALL NOT flush a held word.
REQ-032 ptr SHALL be retained across mode changes.
REQ-033 In fixed mode with s >= N, there SHALL be no grant, and all x_ready bits SHALL be 0.

Reset
REQ-034 While reset = 1 at a rising edge, the next state SHALL be f = 0, f_sel = 0, f_valid = 0 and ptr = 0.
REQ-035 While reset = 1, x_ready SHALL be all-zero regardless of the other inputs.
REQ-036 Reset asserted mid-stream SHALL discard the held word, and no accept SHALL be recorded that cycle.
REQ-037 The first cycle after reset deasserts SHALL behave as if the output register is empty.

Verification (N=4, W=8)
REQ-038 Reset check: reset for 2 cycles with all x_valid = 1 -> x_ready = 0000; after release f_valid = 0, f = 0x00, f_sel = 0.
REQ-039 Fixed mode: mode = 0, s = 2, x[2] = 0xA5, x_valid = 0100, f_ready = 1 -> x_ready = 0100; next cycle f = 0xA5, f_sel = 2, f_valid = 1.
REQ-040 Round-robin fairness: mode = 1, x_valid = 1111, f_ready = 1 for 8 cycles -> f_sel sequence 0,1,2,3,0,1,2,3, with ptr wrapping 3 -> 0.
REQ-041 Backpressure: f_valid = 1 with f = 0x11, f_ready = 0 for 3 cycles, x_valid = 1111 -> f holds 0x11 and x_ready = 0000 throughout; f_ready = 1 then accepts exactly one new word.
REQ-042 Sparse round-robin: mode = 1, ptr = 3, x_valid = 0110 -> channel 1 granted, then ptr = 2; next grant is channel 2.
REQ-043 Drain and reset: no x_valid and f_ready = 1 -> f_valid falls next cycle with f held; reset during a held word -> f_valid = 0 next cycle and f = 0x00.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// N-to-1 registered multiplexer with valid/ready handshakes.
// Channel choice is either a fixed select or round-robin across the valid channels.
module mux_nx1_reg #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  x,
  input  logic [N-1:0]    x_valid,
  output logic [N-1:0]    x_ready,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  output logic [W-1:0]    f,
  output logic            f_valid,
  input  logic            f_ready,
  output logic [SW-1:0]   f_sel
);

  logic [W-1:0]  f_q, f_d;
  logic [SW-1:0] f_sel_q, f_sel_d;
  logic          f_valid_q, f_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          ld, grant, accept;
  logic          fx_grant, rr_grant, s_ok;
  logic [SW-1:0] c, rr_idx;
  logic [SW:0]   probe;

  // Round-robin search: ptr, ptr+1, ... wrapping at N (not at 2**SW).
  always_comb begin
    rr_grant = 1'b0;
    rr_idx   = '0;
    probe    = '0;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, ptr_q} + (SW+1)'(k);
      if (probe >= (SW+1)'(N)) probe = probe - (SW+1)'(N);
      if (!rr_grant && x_valid[probe[SW-1:0]]) begin
        rr_grant = 1'b1;
        rr_idx   = probe[SW-1:0];
      end
    end
  end

  assign s_ok     = ({1'b0, s} < (SW+1)'(N));
  assign fx_grant = s_ok && x_valid[s];
  assign c        = mode ? rr_idx : s;
  assign grant    = mode ? rr_grant : fx_grant;
  assign ld       = ~f_valid_q | f_ready;
  assign accept   = ~reset & ld & grant;
  assign x_ready  = accept ? ({{(N-1){1'b0}}, 1'b1} << c) : '0;

  always_comb begin
    f_d       = f_q;
    f_sel_d   = f_sel_q;
    f_valid_d = f_valid_q;
    ptr_d     = ptr_q;
    if (accept) begin
      f_d       = x[c*W +: W];
      f_sel_d   = c;
      f_valid_d = 1'b1;
      ptr_d     = (c == SW'(N-1)) ? '0 : c + SW'(1);
    end else if (ld) begin
      // No grant: the slot empties but the last word stays visible on f/f_sel.
      f_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q       <= '0;
      f_sel_q   <= '0;
      f_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      f_q       <= f_d;
      f_sel_q   <= f_sel_d;
      f_valid_q <= f_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign f       = f_q;
  assign f_sel   = f_sel_q;
  assign f_valid = f_valid_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Scoreboard bench for mux_nx1_reg: directed scenarios followed by random traffic,
// checked against a channel-level reference model.
module tb_mux_nx1_reg;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*W-1:0]  x = '0;
  logic [N-1:0]    x_valid = '0;
  logic [N-1:0]    x_ready;
  logic [SW-1:0]   s = '0;
  logic            mode = 1'b0;
  logic [W-1:0]    f;
  logic            f_valid;
  logic            f_ready = 1'b0;
  logic [SW-1:0]   f_sel;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W+SW-1:0] sb_q[$];
  bit              m_full = 0;
  logic [W-1:0]    m_f = '0;
  int              m_sel = 0;
  int              m_ptr = 0;

  mux_nx1_reg #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .s(s), .mode(mode), .f(f), .f_valid(f_valid), .f_ready(f_ready), .f_sel(f_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit md, input int sel, input logic [N-1:0] xv, input int ptr);
    if (!md) return (sel < N && xv[sel]) ? sel : -1;
    for (int k = 0; k < N; k++)
      if (xv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock cycle: drive after the edge, check mid-cycle, advance the model.
  task automatic step(input bit rst, input bit md, input int sel, input logic [N-1:0] xv,
                      input logic [N*W-1:0] xd, input bit fr);
    int c;
    bit ld;
    logic [N-1:0] exp_xr;
    @(posedge clk);
    #1;
    reset = rst; mode = md; s = SW'(sel); x_valid = xv; x = xd; f_ready = fr;
    @(negedge clk);
    ld = !m_full || fr;
    c  = pick(md, sel, xv, m_ptr);
    exp_xr = (!rst && ld && c >= 0) ? N'(1 << c) : '0;
    chk("x_ready", 32'(x_ready), 32'(exp_xr));
    chk("f_valid", 32'(f_valid), 32'(m_full));
    chk("f", 32'(f), 32'(m_f));
    chk("f_sel", 32'(f_sel), 32'(m_sel));
    if (rst) begin
      m_full = 0; m_f = '0; m_sel = 0; m_ptr = 0;
      sb_q.delete();
    end else if (ld) begin
      if (c >= 0) begin
        m_f    = xd[c*W +: W];
        m_sel  = c;
        m_full = 1;
        m_ptr  = (c + 1) % N;
        sb_q.push_back({m_f, SW'(c)});
      end else begin
        m_full = 0;
      end
    end
  endtask

  // Monitor: every output handshake must deliver the oldest accepted word.
  initial begin
    logic [W+SW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && f_valid && f_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("sb_word", 32'({f, f_sel}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] xd;
    // reset with all channels valid
    step(1, 0, 0, 4'b1111, 32'h44332211, 1);
    step(1, 1, 0, 4'b1111, 32'h44332211, 1);
    step(0, 0, 0, 4'b0000, 32'h0, 1);
    chk("rst_f_valid", 32'(f_valid), 32'(0));

    // fixed select of channel 2
    step(0, 0, 2, 4'b0100, 32'h00A50000, 1);
    chk("fixed_x_ready", 32'(x_ready), 32'(4'b0100));
    step(0, 0, 2, 4'b0000, 32'h0, 1);
    chk("fixed_f", 32'({f_valid, f_sel, f}), 32'({1'b1, 2'd2, 8'hA5}));

    // fairness from a fresh pointer
    step(1, 0, 0, 4'b0000, 32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 4'b1111, 32'h40302010 + 32'(i), 1);
      if (i > 0) chk("rr_seq", 32'(f_sel), 32'((i - 1) % N));
    end

    // backpressure: hold 0x11 for three cycles then accept exactly one
    step(0, 0, 0, 4'b0001, 32'h00000011, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b1111, 32'hDDCCBBAA, 0);
    chk("bp_hold", 32'(f), 32'(8'h11));
    step(0, 1, 0, 4'b1111, 32'hDDCCBBAA, 1);
    step(0, 1, 0, 4'b0000, 32'h0, 0);
    step(0, 1, 0, 4'b0000, 32'h0, 1);

    // sparse round-robin from ptr=3
    step(0, 0, 2, 4'b0100, 32'h00770000, 1);
    step(0, 1, 0, 4'b0110, 32'h00886600, 1);
    chk("sparse_grant1", 32'(x_ready), 32'(4'b0010));
    step(0, 1, 0, 4'b0110, 32'h00886600, 1);
    chk("sparse_grant2", 32'(x_ready), 32'(4'b0100));

    // drain, then reset over a held word
    step(0, 1, 0, 4'b0000, 32'h0, 1);
    step(0, 1, 0, 4'b0000, 32'h0, 1);
    chk("drain_f_valid", 32'(f_valid), 32'(0));
    step(0, 0, 3, 4'b1000, 32'h5A000000, 1);
    step(0, 0, 3, 4'b1000, 32'h5A000000, 0);
    step(1, 0, 3, 4'b1000, 32'h5A000000, 0);
    step(0, 0, 0, 4'b0000, 32'h0, 0);
    chk("rst_held_f", 32'({f_valid, f}), 32'(0));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      xd = {$urandom, $urandom};
      step(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, N - 1)),
           N'($urandom), xd, ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 4'b0000, 32'h0, 1);
    step(0, 0, 0, 4'b0000, 32'h0, 1);
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
